// File: rtl/ext_mem_slave_2ch.sv
// Two-channel byte-lane memory slave for the accelerator master port.
// Each lane serves masked byte loads/stores with its own programmable-latency FSM.
module ext_mem_slave_2ch #(
   parameter int ADDR_W      = 7,
   parameter int BASE_ADDR   = 0,
   parameter int MEMSIZE     = 32,
   parameter int READ_DELAY  = 2,
   parameter int WRITE_DELAY = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          Mout_oe_ram,
   input  logic [1:0]          Mout_we_ram,
   input  logic [2*ADDR_W-1:0] Mout_addr_ram,
   input  logic [15:0]         Mout_Wdata_ram,
   input  logic [7:0]          Mout_data_ram_size,
   output logic [15:0]         M_Rdata_ram,
   output logic [1:0]          M_DataRdy,
   output logic                err_conflict,
   output logic                err_range
);

   localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
   localparam logic [ADDR_W:0] LO_A   = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] SIZE_A = (ADDR_W+1)'(MEMSIZE);
   localparam logic [3:0] RD_LOAD = 4'(READ_DELAY - 1);
   localparam logic [3:0] WR_LOAD = 4'(WRITE_DELAY - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [7:0]         mem_q [0:MEMSIZE-1];
   logic [1:0]         rd_go;
   logic [1:0]         wr_go;
   logic [1:0]         conflict;
   logic [1:0]         range_bad;
   logic [2*IDX_W-1:0] idx;
   logic [15:0]        mask;
   logic [7:0]         wr_val0;
   logic [7:0]         wr_val1;
   logic [7:0]         base1;
   logic               err_conflict_q;
   logic               err_range_q;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic [ADDR_W-1:0] addr;
         logic [ADDR_W:0]   offset;
         logic [3:0]        size;
         logic              in_range;
         logic              idle;
         logic              rd_ok;
         logic              wr_ok;
         logic              unused_offset;
         logic [1:0]        state_q, state_d;
         logic [3:0]        cnt_q, cnt_d;
         logic [7:0]        hold_q, hold_d;
         logic              is_rd_q, is_rd_d;

         assign addr   = Mout_addr_ram[gi*ADDR_W +: ADDR_W];
         // Below-base addresses wrap into the upper half, so one compare covers both bounds.
         assign offset   = {1'b0, addr} - LO_A;
         assign in_range = (offset < SIZE_A);
         assign unused_offset = ^offset;
         assign idle   = (state_q == S_IDLE);
         assign size   = Mout_data_ram_size[gi*4 +: 4];

         assign rd_ok = idle & Mout_oe_ram[gi] & ~Mout_we_ram[gi] & in_range;
         assign wr_ok = idle & Mout_we_ram[gi] & ~Mout_oe_ram[gi] & in_range;

         assign rd_go[gi]     = rd_ok;
         assign wr_go[gi]     = wr_ok;
         assign conflict[gi]  = idle & Mout_oe_ram[gi] & Mout_we_ram[gi];
         assign range_bad[gi] = idle & (Mout_oe_ram[gi] | Mout_we_ram[gi]) & ~in_range;
         assign idx[gi*IDX_W +: IDX_W] = offset[IDX_W-1:0];
         assign mask[gi*8 +: 8] = ((size == 4'd0) || (size >= 4'd8)) ? 8'hFF
                                                                    : (8'hFF >> (4'd8 - size));

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hold_d  = hold_q;
            is_rd_d = is_rd_q;
            case (state_q)
               S_IDLE: begin
                  if (rd_ok) begin
                     hold_d  = mem_q[offset[IDX_W-1:0]];
                     is_rd_d = 1'b1;
                     cnt_d   = RD_LOAD;
                     state_d = (READ_DELAY <= 1) ? S_DONE : S_WAIT;
                  end else if (wr_ok) begin
                     is_rd_d = 1'b0;
                     cnt_d   = WR_LOAD;
                     state_d = (WRITE_DELAY <= 1) ? S_DONE : S_WAIT;
                  end
               end
               S_WAIT: begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q <= 4'd1) begin
                     state_d = S_DONE;
                  end
               end
               S_DONE: begin
                  state_d = S_IDLE;
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               state_q <= S_IDLE;
               cnt_q   <= 4'd0;
               hold_q  <= 8'h00;
               is_rd_q <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               hold_q  <= hold_d;
               is_rd_q <= is_rd_d;
            end
         end

         assign M_DataRdy[gi]          = (state_q == S_DONE);
         assign M_Rdata_ram[gi*8 +: 8] = ((state_q == S_DONE) && is_rd_q) ? hold_q : 8'h00;
      end
   endgenerate

   // Same-address writes on one edge: lane 1 merges on top of lane 0's result.
   always_comb begin
      wr_val0 = (Mout_Wdata_ram[7:0] & mask[7:0]) | (mem_q[idx[IDX_W-1:0]] & ~mask[7:0]);
      base1   = (wr_go[0] && (idx[IDX_W-1:0] == idx[2*IDX_W-1:IDX_W])) ? wr_val0
                                                                      : mem_q[idx[2*IDX_W-1:IDX_W]];
      wr_val1 = (Mout_Wdata_ram[15:8] & mask[15:8]) | (base1 & ~mask[15:8]);
   end

   always_ff @(posedge clock) begin
      if (wr_go[0]) begin
         mem_q[idx[IDX_W-1:0]] <= wr_val0;
      end
      if (wr_go[1]) begin
         mem_q[idx[2*IDX_W-1:IDX_W]] <= wr_val1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_conflict_q <= 1'b0;
         err_range_q    <= 1'b0;
      end else begin
         err_conflict_q <= err_conflict_q | (|conflict);
         err_range_q    <= err_range_q | (|range_bad);
      end
   end

   assign err_conflict = err_conflict_q;
   assign err_range    = err_range_q;

endmodule

// File: tb/tb_ext_mem_slave_2ch.sv
// Scoreboard bench for ext_mem_slave_2ch; three instances share stimulus to cover
// several read/write latency settings.
module tb_ext_mem_slave_2ch;

   localparam int AW = 7;
   localparam int RDL [3] = '{2, 5, 1};
   localparam int WDL [3] = '{1, 3, 1};

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [1:0]      oe    = '0;
   logic [1:0]      we    = '0;
   logic [2*AW-1:0] addr  = '0;
   logic [15:0]     wdata = '0;
   logic [7:0]      size  = '0;

   logic [1:0]  rdy_a, rdy_b, rdy_c;
   logic [15:0] rd_a, rd_b, rd_c;
   logic        ec_a, er_a, ec_b, er_b, ec_c, er_c;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   logic [1:0] pend = '0;

   int         fst [3];
   int         lst [3];
   int         cnt [3];
   logic [7:0] dat [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ext_mem_slave_2ch #(.READ_DELAY(2), .WRITE_DELAY(1)) dut_a (
      .clock(clk), .reset(rst_n), .Mout_oe_ram(oe), .Mout_we_ram(we),
      .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
      .M_Rdata_ram(rd_a), .M_DataRdy(rdy_a), .err_conflict(ec_a), .err_range(er_a));

   ext_mem_slave_2ch #(.READ_DELAY(5), .WRITE_DELAY(3)) dut_b (
      .clock(clk), .reset(rst_n), .Mout_oe_ram(oe), .Mout_we_ram(we),
      .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
      .M_Rdata_ram(rd_b), .M_DataRdy(rdy_b), .err_conflict(ec_b), .err_range(er_b));

   ext_mem_slave_2ch #(.READ_DELAY(1), .WRITE_DELAY(1)) dut_c (
      .clock(clk), .reset(rst_n), .Mout_oe_ram(oe), .Mout_we_ram(we),
      .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
      .M_Rdata_ram(rd_c), .M_DataRdy(rdy_c), .err_conflict(ec_c), .err_range(er_c));

   // Scoreboard monitor for dut_a: every DataRdy pops one expectation for its lane.
   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] lane;
      if (mon_en) begin
         for (int c = 0; c < 2; c++) begin
            lane = rd_a[c*8 +: 8];
            if (rdy_a[c]) begin
               if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL sb_unexpected_rdy ch%0d cycle %0d: got DataRdy=1, required 0", c, cyc);
               end else begin
                  if (c == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  n_cmp++;
                  if (lane !== e.data) begin
                     n_bad++;
                     $display("FAIL sb_rdata ch%0d cycle %0d: got %02h, required %02h", c, cyc, lane, e.data);
                  end
                  n_cmp++;
                  if (cyc != e.due) begin
                     n_bad++;
                     $display("FAIL sb_latency ch%0d: DataRdy at cycle %0d, required %0d", c, cyc, e.due);
                  end
                  $display("txn ch%0d cycle %0d rdata %02h", c, cyc, lane);
               end
            end else if (lane !== 8'h00) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_idle_lane ch%0d cycle %0d: got %02h, required 00", c, cyc, lane);
            end
         end
      end
   end

   task automatic issue(input int c, input bit r, input bit w, input int a,
                        input logic [7:0] d, input logic [3:0] s);
      oe[c] = r;
      we[c] = w;
      addr[c*AW +: AW] = AW'(a);
      wdata[c*8 +: 8]  = d;
      size[c*4 +: 4]   = s;
   endtask

   task automatic expect_done(input int c, input logic [7:0] d, input int dly);
      exp_t e;
      e.data = d;
      e.due  = cyc + dly;
      if (c == 0) q0.push_back(e);
      else        q1.push_back(e);
      pend[c] = 1'b1;
   endtask

   // Holds requests until their DataRdy, then idles one cycle so the next request meets IDLE.
   task automatic run(input int budget);
      int n = 0;
      while (pend != 2'b00 && n < budget) begin
         @(negedge clk);
         n++;
         for (int c = 0; c < 2; c++) begin
            if (pend[c] && rdy_a[c]) begin
               oe[c] = 1'b0;
               we[c] = 1'b0;
               pend[c] = 1'b0;
            end
         end
      end
      n_cmp++;
      if (pend != 2'b00) begin
         n_bad++;
         $display("FAIL run_timeout: pending %b after %0d cycles, required 00", pend, n);
         oe = '0;
         we = '0;
         pend = '0;
      end
      @(negedge clk);
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL sb_leftover: %0d/%0d expectations unserved, required 0/0", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   task automatic wr(input int c, input int a, input logic [7:0] d, input logic [3:0] s);
      issue(c, 1'b0, 1'b1, a, d, s);
      expect_done(c, 8'h00, 1);
      run(20);
   endtask

   task automatic rd(input int c, input int a, input logic [7:0] d);
      issue(c, 1'b1, 1'b0, a, 8'h00, 4'd8);
      expect_done(c, d, 2);
      run(20);
   endtask

   // Records lane-0 DataRdy pulses of all three instances; request dropped at negedge 'hold'.
   task automatic observe(input int hold, input int ncyc);
      logic       r;
      logic [7:0] v;
      for (int d = 0; d < 3; d++) begin
         fst[d] = -1;
         lst[d] = -1;
         cnt[d] = 0;
         dat[d] = 8'h00;
      end
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         if (i == hold) begin
            oe = '0;
            we = '0;
         end
         for (int d = 0; d < 3; d++) begin
            r = (d == 0) ? rdy_a[0] : (d == 1) ? rdy_b[0] : rdy_c[0];
            v = (d == 0) ? rd_a[7:0] : (d == 1) ? rd_b[7:0] : rd_c[7:0];
            if (r) begin
               if (cnt[d] == 0) begin
                  fst[d] = cyc;
                  dat[d] = v;
               end
               lst[d] = cyc;
               cnt[d]++;
            end
         end
      end
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({rdy_a, rd_a, ec_a, er_a} !== 20'h0) begin
         n_bad++;
         $display("FAIL reset_a: got %05h, required 00000", {rdy_a, rd_a, ec_a, er_a});
      end
      n_cmp++;
      if ({rdy_b, rd_b, ec_b, er_b} !== 20'h0) begin
         n_bad++;
         $display("FAIL reset_b: got %05h, required 00000", {rdy_b, rd_b, ec_b, er_b});
      end
      n_cmp++;
      if ({rdy_c, rd_c, ec_c, er_c} !== 20'h0) begin
         n_bad++;
         $display("FAIL reset_c: got %05h, required 00000", {rdy_c, rd_c, ec_c, er_c});
      end
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic test_write_read;
      wr(0, 5, 8'hA7, 4'd8);
      rd(0, 5, 8'hA7);
      rd(1, 5, 8'hA7);
      wr(1, 31, 8'h3C, 4'd8);
      rd(0, 31, 8'h3C);
      wr(1, 0, 8'h81, 4'd8);
      rd(1, 0, 8'h81);
   endtask

   task automatic test_masked;
      wr(0, 3, 8'hFF, 4'd8);
      wr(0, 3, 8'h00, 4'd4);
      rd(0, 3, 8'hF0);
      wr(0, 3, 8'h5A, 4'd0);
      rd(0, 3, 8'h5A);
      wr(1, 3, 8'hFF, 4'd3);
      rd(1, 3, 8'h5F);
      wr(0, 3, 8'h00, 4'd12);
      rd(0, 3, 8'h00);
   endtask

   task automatic test_concurrent;
      issue(0, 1'b0, 1'b1, 9, 8'h11, 4'd8);
      issue(1, 1'b0, 1'b1, 9, 8'h22, 4'd8);
      expect_done(0, 8'h00, 1);
      expect_done(1, 8'h00, 1);
      run(20);
      rd(0, 9, 8'h22);
      issue(0, 1'b0, 1'b1, 9, 8'h33, 4'd8);
      issue(1, 1'b1, 1'b0, 9, 8'h00, 4'd8);
      expect_done(0, 8'h00, 1);
      expect_done(1, 8'h22, 2);
      run(20);
      rd(1, 9, 8'h33);
      issue(0, 1'b0, 1'b1, 9, 8'hAB, 4'd8);
      issue(1, 1'b0, 1'b1, 9, 8'h0F, 4'd4);
      expect_done(0, 8'h00, 1);
      expect_done(1, 8'h00, 1);
      run(20);
      rd(0, 9, 8'hAF);
   endtask

   task automatic test_errors;
      n_cmp++;
      if (ec_a !== 1'b0 || er_a !== 1'b0) begin
         n_bad++;
         $display("FAIL err_initial: got conflict=%b range=%b, required 0 0", ec_a, er_a);
      end
      issue(1, 1'b1, 1'b1, 9, 8'h00, 4'd8);
      @(negedge clk);
      oe = '0;
      we = '0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (ec_a !== 1'b1 || er_a !== 1'b0) begin
         n_bad++;
         $display("FAIL err_conflict: got conflict=%b range=%b, required 1 0", ec_a, er_a);
      end
      rd(0, 9, 8'hAF);
      issue(0, 1'b1, 1'b0, 32, 8'h00, 4'd8);
      @(negedge clk);
      oe = '0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (er_a !== 1'b1) begin
         n_bad++;
         $display("FAIL err_range: got %b, required 1", er_a);
      end
      issue(1, 1'b0, 1'b1, 127, 8'hFF, 4'd8);
      @(negedge clk);
      we = '0;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (ec_a !== 1'b1 || er_a !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: got conflict=%b range=%b, required 1 1", ec_a, er_a);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (ec_a !== 1'b0 || er_a !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: got conflict=%b range=%b, required 0 0", ec_a, er_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(0, 9, 8'hAF);
   endtask

   task automatic test_latency;
      int n;
      mon_en = 1'b0;
      repeat (12) @(negedge clk);
      n = cyc;
      issue(0, 1'b0, 1'b1, 20, 8'h5C, 4'd8);
      observe(1, 12);
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (fst[d] != n + WDL[d] || cnt[d] != 1) begin
            n_bad++;
            $display("FAIL lat_wr dut%0d: got first=%0d pulses=%0d, required %0d 1", d, fst[d], cnt[d], n + WDL[d]);
         end
      end
      for (int hold = 1; hold <= 3; hold++) begin
         n = cyc;
         issue(0, 1'b1, 1'b0, 20, 8'h00, 4'd8);
         observe(hold, 12);
         for (int d = 0; d < 3; d++) begin
            int want_cnt;
            want_cnt = (d == 2 && hold == 3) ? 2 : 1;
            n_cmp++;
            if (fst[d] != n + RDL[d] || cnt[d] != want_cnt) begin
               n_bad++;
               $display("FAIL lat_rd hold%0d dut%0d: got first=%0d pulses=%0d, required %0d %0d",
                        hold, d, fst[d], cnt[d], n + RDL[d], want_cnt);
            end
            n_cmp++;
            if (dat[d] !== 8'h5C) begin
               n_bad++;
               $display("FAIL lat_rdata hold%0d dut%0d: got %02h, required 5C", hold, d, dat[d]);
            end
         end
         if (hold == 3) begin
            n_cmp++;
            if (lst[2] != n + 3) begin
               n_bad++;
               $display("FAIL lat_reaccept: second pulse at %0d, required %0d", lst[2], n + 3);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      int n;
      n = cyc;
      issue(0, 1'b1, 1'b0, 20, 8'h00, 4'd8);
      @(negedge clk);
      n_cmp++;
      if (rdy_c[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_pre_done: got DataRdy=%b, required 1", rdy_c[0]);
      end
      oe = '0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rdy_c !== 2'b00 || rd_c !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_async: got DataRdy=%b rdata=%04h, required 00 0000", rdy_c, rd_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      issue(0, 1'b1, 1'b0, 20, 8'h00, 4'd8);
      @(negedge clk);
      oe = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rdy_b !== 2'b00 || rd_b !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_mid_out: got DataRdy=%b rdata=%04h, required 00 0000", rdy_b, rd_b);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      observe(0, 10);
      n_cmp++;
      if (cnt[1] != 0) begin
         n_bad++;
         $display("FAIL rst_mid_abort: got %0d DataRdy pulses, required 0", cnt[1]);
      end
      n = cyc;
      issue(0, 1'b1, 1'b0, 20, 8'h00, 4'd8);
      observe(1, 12);
      n_cmp++;
      if (fst[1] != n + 5 || cnt[1] != 1 || dat[1] !== 8'h5C) begin
         n_bad++;
         $display("FAIL rst_fresh_read: got first=%0d pulses=%0d data=%02h, required %0d 1 5C",
                  fst[1], cnt[1], dat[1], n + 5);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_masked();
      test_concurrent();
      test_errors();
      test_latency();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ext_mem_slave_2ch.md
Name: ext_mem_slave_2ch

Overview:
- Synthesizable two-channel external-memory slave that sits directly downstream of the HLS accelerator's master memory port (Mout_* / M_* bus).
- Serves byte-wide loads and stores from a local byte array with programmable read and write latency per access.
- Replaces behavioural off-chip memory models, so FPGA bring-up and emulation run the same accelerator-facing protocol.
- Each channel (0 = low byte lane, 1 = high byte lane) runs an independent request/ready handshake.

Parameters:
- ADDR_W, 7: address bits per channel.
- BASE_ADDR, 0: first byte address served.
- MEMSIZE, 32: number of bytes served, range [BASE_ADDR, BASE_ADDR+MEMSIZE).
- READ_DELAY, 2: clock edges from read sample to DataRdy (legal range 1..15).
- WRITE_DELAY, 1: clock edges from write sample to DataRdy (legal range 1..15).

Ports:
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- Mout_oe_ram, in, 2: per-channel read request.
- Mout_we_ram, in, 2: per-channel write request.
- Mout_addr_ram, in, 2*ADDR_W: channel c address at [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram, in, 16: channel c write byte at [c*8 +: 8].
- Mout_data_ram_size, in, 8: channel c size in bits at [c*4 +: 4].
- M_Rdata_ram, out, 16: channel c read byte; zero when that channel's DataRdy is low.
- M_DataRdy, out, 2: one-cycle completion pulse per channel.
- err_conflict, out, 1: sticky flag; oe and we seen together on a channel.
- err_range, out, 1: sticky flag; request seen outside the served range.

Behaviour:
- Reset (reset=0, asynchronous):
  - M_DataRdy=0, M_Rdata_ram=0, err_conflict=0, err_range=0.
  - Both channel FSMs go to IDLE; latency counters clear.
  - Memory array contents are not reset.
  - Reset asserted mid-access aborts the access: no DataRdy; a write already committed stays committed.
- Per-channel FSM: IDLE -> WAIT -> DONE -> IDLE.
- IDLE, request sampled at a rising edge:
  - Valid read: oe=1, we=0, address in range.
    - The edge captures mem[addr-BASE_ADDR] into a holding register.
    - Counter loads READ_DELAY-1; go to WAIT, or straight to DONE if READ_DELAY=1.
  - Valid write: we=1, oe=0, address in range.
    - The edge writes the byte: mem = (wdata & mask) | (mem & ~mask).
    - mask = (1<<size)-1 for size 1..7; mask = 0xFF for size 0 or size >= 8.
    - Counter loads WRITE_DELAY-1; go to WAIT, or to DONE if WRITE_DELAY=1.
  - oe=1 and we=1: set err_conflict, no access, stay IDLE.
  - Request with address out of range: set err_range, no access, stay IDLE, no DataRdy.
- WAIT: counter decrements each edge; at 0 go to DONE.
- DONE (exactly one cycle):
  - M_DataRdy[c]=1.
  - For a read, M_Rdata_ram lane c = holding register; for a write, lane c = 0.
  - The edge leaving DONE ignores requests; sampling resumes at the next edge.
- Latency:
  - DataRdy is high in the cycle following edge k+D-1, where k is the sampling edge and D the delay.
  - READ_DELAY=2, sampled at edge 0: DataRdy high between edges 1 and 2.
- Input hold: inputs are ignored while in WAIT/DONE. The master holds its request until DataRdy; changes mid-access have no effect.
- Same-edge events across channels:
  - Both channels write the same address: both masks apply; channel 1 wins on overlapping bits.
  - Read on one channel and write on the other to the same address: the read returns pre-write data.
- Address arithmetic: compare in ADDR_W+1 bits, so BASE_ADDR+MEMSIZE reaching 2^ADDR_W does not wrap.
- Error flags stay set until reset.

Test Plan:
- Write/read, channel 0, defaults: write addr 5, data 0xA7, size 8 at edge 0 -> DataRdy[0] high cycle 1. Read addr 5 at edge 3 -> DataRdy[0] high cycle 5, M_Rdata_ram[7:0]=0xA7, lane 1 = 0.
- Masked write: mem[3]=0xFF, then write 0x00 with size 4 -> readback 0xF0. Write with size 0 -> full byte written.
- Concurrent channels:
  - Channel 0 writes 0x11 and channel 1 writes 0x22 to addr 9 on the same edge -> readback 0x22.
  - Channel 1 reads addr 9 while channel 0 writes 0x33 -> read returns the old value; a later read returns 0x33.
- Errors:
  - oe=we=1 on channel 1 -> err_conflict=1, no DataRdy, memory unchanged.
  - Read addr 32 (MEMSIZE=32) -> err_range=1, no DataRdy.
  - Both flags hold until reset.
- Latency sweep, READ_DELAY in {1,2,5} and WRITE_DELAY in {1,3}: DataRdy is exactly D cycles after the sampling edge and is one cycle wide. A request held through DONE is not double-served; a new request is accepted 1 cycle after DONE.
- Reset mid-access: READ_DELAY=5, assert reset 2 cycles into WAIT -> outputs 0 immediately, no DataRdy. After release, a fresh read completes normally.
